relay_rx_deframer: RTL and testbench
====================================

# relay_rx_deframer

Receive-side deframer for the Proxmark-to-Proxmark relay link, clocked at 13.56 MHz. It sits directly upstream of the relay bridge, on the `data_in` path. It cleans the raw relay line with a majority filter and recovers bit timing from line edges. It then hunts for the 4-bit sync preamble and delivers each following 8-bit payload as a byte through a valid/ack holding register, with overrun reporting and a delivered-byte counter.

## Interface
- `BIT_PERIOD`, default 16: ck_1356meg cycles per line bit (relay line runs at 847.5 kbit/s); power of two, 8..64.
- `SYNC_PATTERN`, default 4'hA: preamble, MSB received first.
- `ck_1356meg`  in  1  sole clock, 13.56 MHz, all state on rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = decode; 0 = receive logic held idle.
- `data_in`  in  1  raw relay line, asynchronous to nothing (same clock domain), idle low.
- `byte_ack`  in  1  consumer accepts `byte_out` on any edge where `byte_valid`=1.
- `ovr_clr`  in  1  clears `overrun`.
- `byte_out`  out  8  last received payload, MSB first on the line.
- `byte_valid`  out  1  holding register full.
- `overrun`  out  1  sticky: a completed byte was discarded.
- `frame_active`  out  1  1 while in PAYLOAD.
- `frame_cnt`  out  8  bytes loaded into holding register, wraps 255→0.

## Operation
- Majority filter: 8-bit shift register `win` takes `data_in` each clock; `filt` is registered `popcount(win) >= 4`.
- Edge detect: `filt_d` is `filt` delayed one clock; `edge` = `filt ^ filt_d`.
- Phase counter `phase`: log2(BIT_PERIOD) bits, free-running modulo BIT_PERIOD, forced to 0 on `edge` (in all non-IDLE states). Sample strobe when `phase == BIT_PERIOD/2 - 1`; the sampled bit = `filt`.
- States:
  - IDLE: entered when `enable`=0. `win`, `phase`, sync reg, bit count and shift reg are cleared. `byte_valid`, `byte_out` and `overrun` are held, so the consumer can drain. Exit to HUNT when `enable`=1.
  - HUNT: each strobe shifts the sampled bit into the 4-bit sync reg. When the register equals `SYNC_PATTERN` after a shift → PAYLOAD, with the sync reg and bit count cleared.
  - PAYLOAD: each strobe shifts the bit into the 8-bit shift reg, MSB first, and increments the 3-bit bit count. On the 8th strobe the state returns to HUNT and the byte completes.
- Byte completion:
  - If `byte_valid`=0, or `byte_valid`=1 and `byte_ack`=1 on the same edge: load `byte_out`, set `byte_valid`=1, increment `frame_cnt`.
  - Otherwise: discard the byte and set `overrun`=1; `byte_out` and `frame_cnt` are unchanged.
- `byte_ack` with `byte_valid`=1 and no load on that edge clears `byte_valid`. `byte_ack` while `byte_valid`=0 is ignored.
- `ovr_clr` clears `overrun`. If an overrun occurs on the same edge, set wins.
- `enable` falling mid-PAYLOAD aborts the partial byte: nothing is loaded and there is no overrun.
- The sync reg is not cleared on entry to HUNT. A payload tail can therefore help form the next preamble; this is accepted protocol behaviour.

## Timing
- Reset (`nreset`=0, async): state HUNT. All registers 0: `byte_out`=0, `byte_valid`=0, `overrun`=0, `frame_active`=0, `frame_cnt`=0, `win`=0, `filt`=0.
- Filter latency for a clean level change on `data_in`:
  - Rising: `filt` rises on the 5th clock edge after the change (4 new samples, plus 1 register stage).
  - Falling: `filt` falls on the 6th clock edge (5 new zeros needed, plus 1 register stage).
- `phase` reads 0 on the edge after `filt` toggles. The strobe follows BIT_PERIOD/2 clocks later, so it sits mid-bit.
- Glitches of ≤3 clocks inside a bit never toggle `filt`.
- Drift tolerance: each bit contains an edge or follows one. Tolerated run length without edges is ≥8 bits at ±1 clock/bit error.
- `frame_active` rises on the edge after the strobe that matched sync. It falls on the edge after the 8th payload strobe, which is the same edge that loads `byte_valid`/`byte_out`.
- Byte latency: `byte_valid`=1 one clock after the strobe of the last payload bit.

## Test plan
- Reset mid-frame: drive preamble plus 4 payload bits, pulse `nreset` low for 3 clocks → all outputs 0. The remainder of that frame yields no byte unless it contains 4'hA.
- Clean frame: `enable`=1, line bits 1010 then 0x5C, 16 clocks/bit, no ack → `byte_out`=0x5C, `byte_valid`=1, `frame_cnt`=1, `overrun`=0.
- Glitch immunity: same frame with 2-clock inverted spikes at clock 3 of every bit → `byte_out`=0x5C, exactly one load.
- Overrun: frames 0x5C then 0xA3, no ack → `byte_out`=0x5C, `frame_cnt`=1, `overrun`=1. Then pulse `ovr_clr` → `overrun`=0.
- Simultaneous ack and load: hold 0x5C valid, assert `byte_ack` exactly on the completion edge of 0xA3 → `byte_valid` stays 1, `byte_out`=0xA3, `frame_cnt`=2, `overrun`=0.
- Drift and abort: frames sent at 15 and 17 clocks/bit decode correctly. Drop `enable` after 5 payload bits → no load, no overrun, `frame_active`=0 next edge.

Source files
------------

// File: rtl/relay_rx_deframer.sv
// Relay-link receive deframer: majority-filters the raw line, locks bit timing to line edges,
// hunts for the sync preamble and delivers each payload byte through a valid/ack register.
module relay_rx_deframer #(
    parameter int unsigned BIT_PERIOD   = 16,
    parameter logic [3:0]  SYNC_PATTERN = 4'hA
) (
    input  logic       ck_1356meg,
    input  logic       nreset,
    input  logic       enable,
    input  logic       data_in,
    input  logic       byte_ack,
    input  logic       ovr_clr,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       overrun,
    output logic       frame_active,
    output logic [7:0] frame_cnt
);

    localparam int unsigned PW = $clog2(BIT_PERIOD);
    localparam logic [PW-1:0] STROBE_PHASE = PW'(BIT_PERIOD / 2 - 1);

    typedef enum logic [1:0] {StIdle, StHunt, StPayload} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_win, w_win_nxt;
    logic          r_filt, r_filt_d;
    logic [PW-1:0] r_phase, w_phase_nxt;
    logic [3:0]    r_sync, w_sync_nxt, w_sync_shift;
    logic [2:0]    r_bitcnt, w_bitcnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_byte_out, w_byte_out_nxt;
    logic          r_byte_valid, w_byte_valid_nxt;
    logic          r_overrun, w_overrun_nxt;
    logic [7:0]    r_frame_cnt, w_frame_cnt_nxt;
    logic [3:0]    w_ones;
    logic          w_edge, w_strobe, w_done, w_load;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + 4'(r_win[i]);
        end
    end

    assign w_edge       = r_filt ^ r_filt_d;
    assign w_strobe     = (r_phase == STROBE_PHASE);
    assign w_sync_shift = {r_sync[2:0], r_filt};
    assign w_win_nxt    = enable ? {r_win[6:0], data_in} : 8'h00;

    // Every line edge re-centres the strobe; with no edge the phase free-runs.
    always_comb begin
        w_phase_nxt = r_phase + PW'(1);
        if (!enable || w_edge) begin
            w_phase_nxt = '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sync_nxt   = r_sync;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_done       = 1'b0;
        if (!enable) begin
            w_state_nxt  = StIdle;
            w_sync_nxt   = '0;
            w_bitcnt_nxt = '0;
            w_shift_nxt  = '0;
        end else begin
            unique case (r_state)
                StIdle: w_state_nxt = StHunt;
                StHunt: begin
                    if (w_strobe) begin
                        if (w_sync_shift == SYNC_PATTERN) begin
                            w_state_nxt  = StPayload;
                            w_sync_nxt   = '0;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_sync_nxt = w_sync_shift;
                        end
                    end
                end
                StPayload: begin
                    if (w_strobe) begin
                        // Sync keeps shifting so a payload tail can seed the next preamble.
                        w_sync_nxt   = w_sync_shift;
                        w_shift_nxt  = {r_shift[6:0], r_filt};
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_done      = 1'b1;
                            w_state_nxt = StHunt;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    assign w_load = w_done && (!r_byte_valid || byte_ack);

    always_comb begin
        w_byte_out_nxt   = r_byte_out;
        w_byte_valid_nxt = r_byte_valid;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_overrun_nxt    = r_overrun;
        if (w_load) begin
            w_byte_out_nxt   = w_shift_nxt;
            w_byte_valid_nxt = 1'b1;
            w_frame_cnt_nxt  = r_frame_cnt + 8'd1;
        end else if (byte_ack && r_byte_valid) begin
            w_byte_valid_nxt = 1'b0;
        end
        if (w_done && !w_load) begin
            w_overrun_nxt = 1'b1;
        end else if (ovr_clr) begin
            w_overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            r_state <= StHunt;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            r_win        <= '0;
            r_filt       <= 1'b0;
            r_filt_d     <= 1'b0;
            r_phase      <= '0;
            r_sync       <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_win        <= w_win_nxt;
            r_filt       <= (w_ones >= 4'd4);
            r_filt_d     <= r_filt;
            r_phase      <= w_phase_nxt;
            r_sync       <= w_sync_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_out   <= w_byte_out_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_overrun    <= w_overrun_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    assign byte_out     = r_byte_out;
    assign byte_valid   = r_byte_valid;
    assign overrun      = r_overrun;
    assign frame_active = (r_state == StPayload);
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_relay_rx_deframer.sv
// Bench for relay_rx_deframer: directed frames with literal expectations plus randomized
// frames, all checked every cycle against a sample-history reference model.
module tb_relay_rx_deframer;

    localparam int         BP    = 16;
    localparam logic [3:0] SYNC  = 4'hA;
    localparam int         MIdle = 0;
    localparam int         MHunt = 1;
    localparam int         MPay  = 2;

    logic       clk = 1'b0;
    logic       nreset, enable, data_in, byte_ack, ovr_clr;
    logic [7:0] byte_out;
    logic       byte_valid, overrun, frame_active;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_mode = 0;
    bit ack_req = 1'b0;
    bit clr_req = 1'b0;
    bit clr_rand = 1'b0;

    // Reference model state: raw sample history, filtered level, cycles since last edge,
    // recent sampled bits and holding-register contents.
    int         hist [8];
    bit         m_filt = 1'b0;
    bit         m_filt_prev = 1'b0;
    int         m_since = 0;
    int         m_mode = MHunt;
    int         bits [$];
    int         m_nbits = 0;
    logic [7:0] m_out = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_ovr = 1'b0;
    logic [7:0] m_cnt = 8'h00;

    always #5 clk = ~clk;

    relay_rx_deframer #(
        .BIT_PERIOD  (BP),
        .SYNC_PATTERN(SYNC)
    ) u_dut (
        .ck_1356meg  (clk),
        .nreset      (nreset),
        .enable      (enable),
        .data_in     (data_in),
        .byte_ack    (byte_ack),
        .ovr_clr     (ovr_clr),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .overrun     (overrun),
        .frame_active(frame_active),
        .frame_cnt   (frame_cnt)
    );

    function automatic int lastn(input int n);
        int v;
        v = 0;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = bits.size() - n + i;
            v = v * 2 + ((idx >= 0) ? bits[idx] : 0);
        end
        return v;
    endfunction

    always @(posedge clk or negedge nreset) begin : model
        int   ones;
        bit   eg, strobe, done, load;
        logic [7:0] val;
        if (!nreset) begin
            for (int i = 0; i < 8; i++) hist[i] = 0;
            m_filt = 0; m_filt_prev = 0; m_since = 0; m_mode = MHunt;
            bits.delete(); m_nbits = 0;
            m_out = 8'h00; m_valid = 0; m_ovr = 0; m_cnt = 8'h00;
        end else begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += hist[i];
            eg = (m_filt != m_filt_prev);
            strobe = (m_since == BP / 2 - 1);
            done = 0;
            val = 8'h00;
            if (!enable) begin
                m_mode = MIdle;
                bits.delete();
                m_nbits = 0;
            end else if (m_mode == MIdle) begin
                m_mode = MHunt;
            end else if (strobe) begin
                bits.push_back(int'(m_filt));
                if (bits.size() > 8) void'(bits.pop_front());
                if (m_mode == MHunt) begin
                    if (lastn(4) == int'(SYNC)) begin
                        m_mode = MPay;
                        m_nbits = 0;
                    end
                end else begin
                    m_nbits++;
                    if (m_nbits == 8) begin
                        done = 1;
                        val = 8'(lastn(8));
                        m_mode = MHunt;
                    end
                end
            end
            load = done && (!m_valid || byte_ack);
            if (load) begin
                m_out = val; m_valid = 1; m_cnt = m_cnt + 8'd1;
            end else if (byte_ack && m_valid) begin
                m_valid = 0;
            end
            if (done && !load) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
            m_since = (!enable || eg) ? 0 : (m_since + 1) % BP;
            m_filt_prev = m_filt;
            m_filt = (ones >= 4);
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = enable ? int'(data_in) : 0;
            if (!enable) for (int i = 0; i < 8; i++) hist[i] = 0;
        end
    end

    task automatic cyc();
        bit done_next;
        @(negedge clk);
        n_cmp++;
        if (byte_out !== m_out || byte_valid !== m_valid || overrun !== m_ovr ||
            frame_active !== (m_mode == MPay) || frame_cnt !== m_cnt) begin
            n_bad++;
            $display("FAIL model t=%0t out=%h/%h valid=%b/%b ovr=%b/%b active=%b/%b cnt=%0d/%0d (dut/model)",
                     $time, byte_out, m_out, byte_valid, m_valid, overrun, m_ovr,
                     frame_active, (m_mode == MPay), frame_cnt, m_cnt);
        end
        done_next = enable && m_mode == MPay && m_nbits == 7 && m_since == BP / 2 - 1;
        byte_ack = ack_req || (ack_mode == 1 && done_next) ||
                   (ack_mode == 2 && $urandom_range(0, 199) == 0);
        ovr_clr = clr_req || (clr_rand && $urandom_range(0, 299) == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic gap(input int n);
        data_in = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send_bit(input logic b, input int cpb, input bit gl);
        for (int c = 0; c < cpb; c++) begin
            data_in = (gl && (c == 3 || c == 4)) ? ~b : b;
            cyc();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb, input bit gl, input int npay);
        logic [3:0] s;
        s = SYNC;
        for (int i = 3; i >= 0; i--) send_bit(s[i], cpb, gl);
        for (int i = 7; i >= 8 - npay; i--) send_bit(b[i], cpb, gl);
    endtask

    task automatic pulse_ack();
        ack_req = 1'b1; cyc(); ack_req = 1'b0; cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_byte_out"}, byte_out, 0);
        chk({tag, "_byte_valid"}, byte_valid, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_frame_active"}, frame_active, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        int         cpb, npay;
        bit         gl, ab;
        logic [7:0] b;
        nreset = 1'b0; enable = 1'b0; data_in = 1'b0; byte_ack = 1'b0; ovr_clr = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk_all_zero("reset");
        nreset = 1'b1; enable = 1'b1;
        gap(40);

        send_frame(8'h5C, 16, 0, 8); gap(48);
        chk("clean_byte_out", byte_out, 8'h5C);
        chk("clean_model_pin", m_out, 8'h5C);
        chk("clean_valid", byte_valid, 1);
        chk("clean_cnt", frame_cnt, 1);
        chk("clean_overrun", overrun, 0);

        send_frame(8'hA3, 16, 0, 8); gap(48);
        chk("ovr_byte_out", byte_out, 8'h5C);
        chk("ovr_cnt", frame_cnt, 1);
        chk("ovr_set", overrun, 1);
        clr_req = 1'b1; cyc(); clr_req = 1'b0; cyc();
        chk("ovr_clr", overrun, 0);

        ack_mode = 1;
        send_frame(8'hA3, 16, 0, 8); gap(48);
        ack_mode = 0;
        chk("simul_valid", byte_valid, 1);
        chk("simul_byte_out", byte_out, 8'hA3);
        chk("simul_cnt", frame_cnt, 2);
        chk("simul_overrun", overrun, 0);

        pulse_ack();
        chk("drain_valid", byte_valid, 0);
        send_frame(8'h5C, 16, 1, 8); gap(48);
        chk("glitch_byte_out", byte_out, 8'h5C);
        chk("glitch_cnt", frame_cnt, 3);

        pulse_ack();
        send_frame(8'h3C, 15, 0, 8); gap(48);
        chk("drift15_byte_out", byte_out, 8'h3C);
        chk("drift15_cnt", frame_cnt, 4);
        pulse_ack();
        send_frame(8'h96, 17, 0, 8); gap(48);
        chk("drift17_byte_out", byte_out, 8'h96);
        chk("drift17_cnt", frame_cnt, 5);

        send_frame(8'h5C, 16, 0, 5);
        chk("abort_active_before", frame_active, 1);
        enable = 1'b0;
        cyc();
        chk("abort_active_after", frame_active, 0);
        gap(5);
        chk("abort_byte_out", byte_out, 8'h96);
        chk("abort_valid", byte_valid, 1);
        chk("abort_cnt", frame_cnt, 5);
        chk("abort_overrun", overrun, 0);
        enable = 1'b1;
        gap(40);

        send_frame(8'h5C, 16, 0, 4);
        chk("midrst_active_before", frame_active, 1);
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk_all_zero("midrst");
        nreset = 1'b1;
        send_bit(1'b1, 16, 0); send_bit(1'b1, 16, 0);
        send_bit(1'b0, 16, 0); send_bit(1'b0, 16, 0);
        gap(48);
        chk("midrst_tail_valid", byte_valid, 0);
        chk("midrst_tail_cnt", frame_cnt, 0);

        ack_mode = 2; clr_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            cpb = $urandom_range(15, 17);
            gl = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            ab = ($urandom_range(0, 7) == 0);
            if (ab) begin
                npay = $urandom_range(1, 7);
                send_frame(b, cpb, gl, npay);
                enable = 1'b0;
                gap($urandom_range(1, 10));
                enable = 1'b1;
            end else begin
                send_frame(b, cpb, gl, 8);
            end
            gap($urandom_range(20, 80));
        end
        ack_mode = 0; clr_rand = 1'b0;
        gap(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
